// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle HI/LO engine: signed/unsigned multiply, multiply-accumulate/subtract
// and restoring divide, producing the 2W-bit {HI,LO} write value for EX.
module hilo_muldiv_unit #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic [DATA_W-1:0]     hi_i,
   input  logic [DATA_W-1:0]     lo_i,
   input  logic                  annul_i,
   output logic                  stallreq_o,
   output logic                  ready_o,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  div_zero_o,
   output logic [1:0]            dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int W2    = 2 * DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]          state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [W2-1:0]       acc_q, acc_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]       result_q, result_d;
   logic                dz_q, dz_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;

   logic                op_is_div, in_sgn, in_neg1, in_neg2;
   logic [DATA_W-1:0]   mag1, mag2;
   logic [W2-1:0]       ext_a, ext_b, prod, mul_res;
   logic [DATA_W:0]     rem_sh, diff;
   logic                ge;
   logic [DATA_W-1:0]   rem_nx, quo_nx, rem_fin, quo_fin;

   // Handshake: EX holds start_i and the operands while stallreq_o is high; the unit
   // drops stallreq_o in DONE and pulses ready_o there, and annul_i cancels any op.
   assign stallreq_o  = start_i & ~annul_i & (state_q != S_DONE);
   assign ready_o     = (state_q == S_DONE) & ~annul_i;
   assign div_zero_o  = ready_o & dz_q;
   assign result_o    = result_q;
   assign dbg_state_o = state_q;

   always_comb begin
      op_is_div = (op_i[2:1] == 2'b01);
      in_sgn    = ~op_i[0];
      in_neg1   = in_sgn & opdata1_i[DATA_W-1];
      in_neg2   = in_sgn & opdata2_i[DATA_W-1];
      mag1      = in_neg1 ? -opdata1_i : opdata1_i;
      mag2      = in_neg2 ? -opdata2_i : opdata2_i;

      // Multiply on extended operands; the low 2W bits are correct for both signednesses.
      ext_a   = op_q[0] ? {{DATA_W{1'b0}}, a_q} : {{DATA_W{a_q[DATA_W-1]}}, a_q};
      ext_b   = op_q[0] ? {{DATA_W{1'b0}}, b_q} : {{DATA_W{b_q[DATA_W-1]}}, b_q};
      prod    = ext_a * ext_b;
      mul_res = op_q[2] ? (op_q[1] ? acc_q - prod : acc_q + prod) : prod;

      // One restoring step: a_q shifts out dividend bits and collects quotient bits.
      rem_sh  = {rem_q, a_q[DATA_W-1]};
      diff    = rem_sh - {1'b0, b_q};
      ge      = ~diff[DATA_W];
      rem_nx  = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      quo_nx  = {a_q[DATA_W-2:0], ge};
      quo_fin = qneg_q ? -quo_nx : quo_nx;
      rem_fin = rneg_q ? -rem_nx : rem_nx;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      dz_d     = dz_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               op_d   = op_i;
               acc_d  = {hi_i, lo_i};
               cnt_d  = '0;
               rem_d  = '0;
               dz_d   = 1'b0;
               qneg_d = in_neg1 ^ in_neg2;
               rneg_d = in_neg1;
               if (!op_is_div) begin
                  a_d     = opdata1_i;
                  b_d     = opdata2_i;
                  state_d = S_MUL;
               end else if (opdata2_i == '0) begin
                  result_d = '0;
                  dz_d     = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  a_d     = mag1;
                  b_d     = mag2;
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
               result_d = mul_res;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DIV: begin
            rem_d = rem_nx;
            a_d   = quo_nx;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               result_d = {rem_fin, quo_fin};
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over completion: no result is written on an annulled cycle.
      if (annul_i && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         dz_q     <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         dz_q     <= dz_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit (W=32, MUL_LAT=2): directed cases plus random ops,
// with expected {div_zero, HI, LO} queued at issue and compared on ready_o.
module tb_hilo_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [2:0]    op_i;
   logic [W-1:0]  opdata1_i, opdata2_i, hi_i, lo_i;
   logic          annul_i;
   logic          stallreq_o, ready_o, div_zero_o;
   logic [2*W-1:0] result_o;
   logic [1:0]    dbg_state_o;

   logic [2*W:0]  exp_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(2)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
      .annul_i(annul_i), .stallreq_o(stallreq_o), .ready_o(ready_o),
      .result_o(result_o), .div_zero_o(div_zero_o), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: {div_zero, HI, LO} straight from the instruction definitions.
   function automatic logic [2*W:0] model(input logic [2:0] op, input logic [W-1:0] a, b, h, l);
      longint sa, sb, q, r, p;
      logic [63:0] acc, res;
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      if (op[2:1] == 2'b01) begin
         if (b == '0) return {1'b1, 64'd0};
         q = sa / sb;
         r = sa % sb;
         return {1'b0, r[31:0], q[31:0]};
      end
      p   = sa * sb;
      acc = {h, l};
      if (!op[2])     res = p;
      else if (op[1]) res = acc - p;
      else            res = acc + p;
      return {1'b0, res};
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
      if (op[2:1] != 2'b01) return 3;
      return (b == '0) ? 1 : W + 1;
   endfunction

   // Scoreboard side: every ready_o pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [2*W:0] e;
      if (ready_o) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ready", 64'(ready_o), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", result_o, e[63:0]);
            chk("div_zero", 64'(div_zero_o), 64'(e[64]));
         end
      end else begin
         chk("dz_without_ready", 64'(div_zero_o), 64'd0);
      end
   end

   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, b, h, l);
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, h, l,
                         input logic [2*W:0] exp, input int lat, input bit chk_stall);
      int k;
      bit seen;
      @(negedge clk);
      drive(op, a, b, h, l);
      exp_q.push_back(exp);
      #1;
      if (chk_stall) chk("stall_t0", 64'(stallreq_o), 64'd1);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (ready_o) seen = 1'b1;
         else if (chk_stall) chk("stall_busy", 64'(stallreq_o), 64'd1);
      end
      chk("latency", 64'(k), 64'(lat));
      if (chk_stall) chk("stall_done", 64'(stallreq_o), 64'd0);
      start_i = 1'b0;
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b, h, l;
      rst = 1'b0; start_i = 1'b0; op_i = '0; opdata1_i = '0; opdata2_i = '0;
      hi_i = '0; lo_i = '0; annul_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 64'(dbg_state_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_dz", 64'(div_zero_o), 64'd0);
      chk("rst_stall", 64'(stallreq_o), 64'd0);
      rst = 1'b1;

      run_op(3'b000, 32'hFFFFFFFE, 32'd3, '0, '0, {1'b0, 64'hFFFFFFFF_FFFFFFFA}, 3, 1'b1);
      run_op(3'b001, 32'hFFFFFFFE, 32'd3, '0, '0, {1'b0, 64'h00000002_FFFFFFFA}, 3, 1'b1);
      run_op(3'b010, 32'hFFFFFFF9, 32'd2, '0, '0, {1'b0, 64'hFFFFFFFF_FFFFFFFD}, 33, 1'b1);
      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, '0, '0, {1'b0, 64'h00000000_80000000}, 33, 1'b0);
      run_op(3'b011, 32'd5, 32'd0, '0, '0, {1'b1, 64'd0}, 1, 1'b1);
      run_op(3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, {1'b0, 64'h00000001_00000000}, 3, 1'b0);
      run_op(3'b110, 32'd1, 32'd1, 32'd0, 32'd0, {1'b0, 64'hFFFFFFFF_FFFFFFFF}, 3, 1'b0);

      // Flush a DIVU at t+10, then restart the same op in the following IDLE cycle.
      @(negedge clk);
      drive(3'b011, 32'd100, 32'd7, '0, '0);
      repeat (10) @(negedge clk);
      annul_i = 1'b1;
      #1;
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      chk("annul_idle", 64'(dbg_state_o), 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      run_op(3'b011, 32'd100, 32'd7, '0, '0, {1'b0, 64'h00000002_0000000E}, 33, 1'b0);

      // Reset while in MUL: no pulse, outputs cleared, then a normal MULT.
      @(negedge clk);
      drive(3'b000, 32'd7, 32'd9, '0, '0);
      @(negedge clk);
      chk("mul_state", 64'(dbg_state_o), 64'd1);
      rst = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'(dbg_state_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      chk("midrst_ready", 64'(ready_o), 64'd0);
      rst = 1'b1;
      run_op(3'b000, 32'd7, 32'hFFFFFFF7, '0, '0, {1'b0, 64'hFFFFFFFF_FFFFFFC1}, 3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         h  = $urandom;
         l  = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: b = $urandom;
         endcase
         run_op(op, a, b, h, l, model(op, a, b, h, l), exp_lat(op, b), 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
